// File: rtl/vga_sprite_renderer_if.sv
// vga_sprite_renderer_if: raster position, shadowed object state and pixel output bundle
//   h_count/v_count                     raster position from the timing generator
//   player_x, alien_x/y, alien_alive,
//   bullet_x/y, bullet_active           live game state, latched once per frame
//   VGA_R/G/B, pixel_valid              registered colour, 2 cycles after position
//   frame_start                         pulse after the shadow registers load
//   modport slave: renderer side; modport master: driver/game side
interface vga_sprite_renderer_if;
   logic [9:0]  h_count;
   logic [9:0]  v_count;
   logic [9:0]  player_x;
   logic [9:0]  alien_x;
   logic [9:0]  alien_y;
   logic [31:0] alien_alive;
   logic [9:0]  bullet_x;
   logic [9:0]  bullet_y;
   logic        bullet_active;
   logic [7:0]  VGA_R;
   logic [7:0]  VGA_G;
   logic [7:0]  VGA_B;
   logic        pixel_valid;
   logic        frame_start;
   modport slave (
      input  h_count, v_count, player_x, alien_x, alien_y, alien_alive,
             bullet_x, bullet_y, bullet_active,
      output VGA_R, VGA_G, VGA_B, pixel_valid, frame_start
   );
   modport master (
      output h_count, v_count, player_x, alien_x, alien_y, alien_alive,
             bullet_x, bullet_y, bullet_active,
      input  VGA_R, VGA_G, VGA_B, pixel_valid, frame_start
   );
endinterface

// File: rtl/vga_sprite_renderer.sv
// vga_sprite_renderer: two-stage pixel colour pipeline for player, alien grid and bullet
//   VGA_CLK  pixel clock, rising edge
//   reset    synchronous, active-high
//   vga      vga_sprite_renderer_if.slave: raster position and live object state in,
//            RGB/pixel_valid (2-cycle latency) and frame_start out
module vga_sprite_renderer #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int PLAYER_Y   = 440,
   parameter int ALIEN_COLS = 8,
   parameter int ALIEN_ROWS = 4,
   parameter int AX_SHIFT   = 5,
   parameter int AY_SHIFT   = 4,
   parameter int BULLET_W   = 2,
   parameter int BULLET_H   = 6
) (
   input logic                  VGA_CLK,
   input logic                  reset,
   vga_sprite_renderer_if.slave vga
);
   localparam int AW = $clog2(ALIEN_COLS * ALIEN_ROWS);
   // row 0 is the least significant 16-bit slice; bit 15 is the leftmost column
   localparam logic [7:0][15:0] PLAYER_ROM = {
      16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFE, 16'h3FFC, 16'h03C0, 16'h03C0, 16'h0180};
   localparam logic [7:0][15:0] ALIEN_ROM = {
      16'hC003, 16'h6006, 16'h3FFC, 16'hFFFF, 16'hE667, 16'h7FFE, 16'h3FFC, 16'hC003};
   logic [9:0]  r_player_x, r_alien_x, r_alien_y, r_bullet_x, r_bullet_y;
   logic [31:0] r_alien_alive;
   logic        r_bullet_active, r_frame_start;
   logic        r_act1, r_p_hit, r_a_hit, r_b_hit, r_valid;
   logic [3:0]  r_p_c, r_a_c;
   logic [2:0]  r_p_r, r_a_r;
   logic [23:0] r_rgb;
   logic        w_load, w_active, w_p_hit, w_a_in, w_b_hit, w_p_px, w_a_px;
   logic [10:0] w_pdx, w_pdy, w_adx, w_ady, w_bdx, w_bdy;
   logic [9-AX_SHIFT:0] w_a_col;
   logic [9-AY_SHIFT:0] w_a_row;
   logic [AW-1:0] w_a_idx;
   logic [23:0] w_rgb;
   assign w_load   = vga.h_count == 10'(H_ACTIVE) && vga.v_count == 10'(V_ACTIVE);
   assign w_active = vga.h_count < 10'(H_ACTIVE) && vga.v_count < 10'(V_ACTIVE);
   // 11-bit differences: bit 10 set means the raster is left of / above the object
   assign w_pdx = {1'b0, vga.h_count} - {1'b0, r_player_x};
   assign w_pdy = {1'b0, vga.v_count} - 11'(PLAYER_Y);
   assign w_adx = {1'b0, vga.h_count} - {1'b0, r_alien_x};
   assign w_ady = {1'b0, vga.v_count} - {1'b0, r_alien_y};
   assign w_bdx = {1'b0, vga.h_count} - {1'b0, r_bullet_x};
   assign w_bdy = {1'b0, vga.v_count} - {1'b0, r_bullet_y};
   assign w_p_hit = !w_pdx[10] && w_pdx[9:0] < 16 && !w_pdy[10] && w_pdy[9:0] < 8;
   assign w_a_col = w_adx[9:AX_SHIFT];
   assign w_a_row = w_ady[9:AY_SHIFT];
   assign w_a_idx = AW'(32'(w_a_row) * ALIEN_COLS + 32'(w_a_col));
   assign w_a_in  = !w_adx[10] && !w_ady[10] && 32'(w_a_col) < ALIEN_COLS
                    && 32'(w_a_row) < ALIEN_ROWS && w_adx[AX_SHIFT-1:0] < 16
                    && w_ady[AY_SHIFT-1:0] < 8;
   assign w_b_hit = r_bullet_active && !w_bdx[10] && w_bdx[9:0] < 10'(BULLET_W)
                    && !w_bdy[10] && w_bdy[9:0] < 10'(BULLET_H);
   // shadow registers only change in the blanking cycle after the last active line
   always_ff @(posedge VGA_CLK) begin
      if (reset) begin
         r_player_x      <= '0;
         r_alien_x       <= '0;
         r_alien_y       <= '0;
         r_alien_alive   <= '0;
         r_bullet_x      <= '0;
         r_bullet_y      <= '0;
         r_bullet_active <= 1'b0;
         r_frame_start   <= 1'b0;
      end else begin
         if (w_load) begin
            r_player_x      <= vga.player_x;
            r_alien_x       <= vga.alien_x;
            r_alien_y       <= vga.alien_y;
            r_alien_alive   <= vga.alien_alive;
            r_bullet_x      <= vga.bullet_x;
            r_bullet_y      <= vga.bullet_y;
            r_bullet_active <= vga.bullet_active;
         end
         r_frame_start <= w_load;
      end
   end
   always_ff @(posedge VGA_CLK) begin
      if (reset) begin
         r_act1  <= 1'b0;
         r_p_hit <= 1'b0;
         r_a_hit <= 1'b0;
         r_b_hit <= 1'b0;
         r_p_c   <= '0;
         r_p_r   <= '0;
         r_a_c   <= '0;
         r_a_r   <= '0;
         r_rgb   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_act1  <= w_active;
         r_p_hit <= w_p_hit;
         r_a_hit <= w_a_in && r_alien_alive[w_a_idx];
         r_b_hit <= w_b_hit;
         r_p_c   <= w_pdx[3:0];
         r_p_r   <= w_pdy[2:0];
         r_a_c   <= w_adx[3:0];
         r_a_r   <= w_ady[2:0];
         r_rgb   <= w_rgb;
         r_valid <= r_act1;
      end
   end
   // ~column maps column 0 onto ROM bit 15
   assign w_p_px = r_p_hit && PLAYER_ROM[r_p_r][~r_p_c];
   assign w_a_px = r_a_hit && ALIEN_ROM[r_a_r][~r_a_c];
   assign w_rgb  = !r_act1 ? 24'h000000 : r_b_hit ? 24'hFFFFFF :
                   w_p_px ? 24'h00FF00 : w_a_px ? 24'hFF00FF : 24'h000000;
   assign vga.VGA_R       = r_rgb[23:16];
   assign vga.VGA_G       = r_rgb[15:8];
   assign vga.VGA_B       = r_rgb[7:0];
   assign vga.pixel_valid = r_valid;
   assign vga.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_sprite_renderer.sv
// tb_vga_sprite_renderer: table-driven scoreboard bench for vga_sprite_renderer
module tb_vga_sprite_renderer;
   typedef struct {
      logic [9:0]  h;
      logic [9:0]  v;
      logic [23:0] rgb;
      logic        pv;
   } vec_t;
   typedef struct {
      int          due;
      logic [9:0]  h;
      logic [9:0]  v;
      logic [23:0] rgb;
      logic        pv;
   } exp_t;
   localparam logic [23:0] BLK = 24'h000000, GRN = 24'h00FF00;
   localparam logic [23:0] MAG = 24'hFF00FF, WHT = 24'hFFFFFF;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t q[$];
   exp_t m_e;
   vec_t va[13];
   vec_t vb[8];
   vec_t vc[10];
   logic [15:0] prow0;
   vga_sprite_renderer_if bus();
   vga_sprite_renderer dut (.VGA_CLK(clk), .reset(rst), .vga(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask
   // values are {rgb, pixel_valid}
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         m_e = q.pop_front();
         chk($sformatf("pixel(%0d,%0d) {rgb,valid}", m_e.h, m_e.v),
             {7'd0, bus.VGA_R, bus.VGA_G, bus.VGA_B, bus.pixel_valid},
             {7'd0, m_e.rgb, m_e.pv});
      end
   end
   task automatic px(input logic [9:0] h, input logic [9:0] v, input bit push,
                     input logic [23:0] rgb, input logic pv);
      bus.h_count = h;
      bus.v_count = v;
      if (push) q.push_back('{cyc + 2, h, v, rgb, pv});
      @(posedge clk);
      #1;
   endtask
   task automatic set_live(input logic [9:0] p, input logic [9:0] ax, input logic [9:0] ay,
                           input logic [31:0] al, input logic [9:0] bx, input logic [9:0] by,
                           input logic ba);
      bus.player_x      = p;
      bus.alien_x       = ax;
      bus.alien_y       = ay;
      bus.alien_alive   = al;
      bus.bullet_x      = bx;
      bus.bullet_y      = by;
      bus.bullet_active = ba;
   endtask
   task automatic load(input logic [9:0] p, input logic [9:0] ax, input logic [9:0] ay,
                       input logic [31:0] al, input logic [9:0] bx, input logic [9:0] by,
                       input logic ba);
      set_live(p, ax, ay, al, bx, by, ba);
      px(10'd640, 10'd480, 1, BLK, 1'b0);
      @(negedge clk);
      chk("frame_start pulse", {31'd0, bus.frame_start}, 32'd1);
      px(10'd641, 10'd480, 1, BLK, 1'b0);
      @(negedge clk);
      chk("frame_start single cycle", {31'd0, bus.frame_start}, 32'd0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      prow0 = 16'h0180;
      // frame A: player 100, aliens at (64,50) with bit 9 dead, bullet inactive
      va = '{
         '{10'd64,  10'd50,  MAG, 1'b1}, '{10'd65,  10'd50,  MAG, 1'b1},
         '{10'd66,  10'd50,  BLK, 1'b1}, '{10'd80,  10'd50,  BLK, 1'b1},
         '{10'd96,  10'd66,  BLK, 1'b1}, '{10'd96,  10'd50,  MAG, 1'b1},
         '{10'd63,  10'd50,  BLK, 1'b1}, '{10'd288, 10'd98,  MAG, 1'b1},
         '{10'd320, 10'd50,  BLK, 1'b1}, '{10'd64,  10'd114, BLK, 1'b1},
         '{10'd64,  10'd58,  BLK, 1'b1}, '{10'd100, 10'd447, GRN, 1'b1},
         '{10'd100, 10'd440, BLK, 1'b1}};
      // frame B: player 300, bullet active at (300,440)
      vb = '{
         '{10'd300, 10'd440, WHT, 1'b1}, '{10'd301, 10'd445, WHT, 1'b1},
         '{10'd302, 10'd440, BLK, 1'b1}, '{10'd307, 10'd440, GRN, 1'b1},
         '{10'd300, 10'd446, GRN, 1'b1}, '{10'd100, 10'd447, BLK, 1'b1},
         '{10'd300, 10'd447, GRN, 1'b1}, '{10'd64,  10'd50,  MAG, 1'b1}};
      // frame C: player 630 straddling right edge, aliens at (64,470), bullet x=1020
      vc = '{
         '{10'd637, 10'd440, GRN, 1'b1}, '{10'd639, 10'd445, GRN, 1'b1},
         '{10'd640, 10'd440, BLK, 1'b0}, '{10'd645, 10'd440, BLK, 1'b0},
         '{10'd700, 10'd300, BLK, 1'b0}, '{10'd64,  10'd470, MAG, 1'b1},
         '{10'd64,  10'd486, BLK, 1'b0}, '{10'd1,   10'd440, BLK, 1'b1},
         '{10'd0,   10'd445, BLK, 1'b1}, '{10'd799, 10'd524, BLK, 1'b0}};
      set_live(10'd0, 10'd0, 10'd0, 32'd0, 10'd0, 10'd0, 1'b0);
      bus.h_count = 10'd700;
      bus.v_count = 10'd500;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      load(10'd100, 10'd64, 10'd50, ~32'h200, 10'd100, 10'd440, 1'b0);
      for (int h = 99; h <= 116; h++)
         px(10'(h), 10'd440, 1, (h >= 100 && h <= 115 && prow0[115 - h]) ? GRN : BLK, 1'b1);
      for (int i = 0; i < $size(va); i++) px(va[i].h, va[i].v, 1, va[i].rgb, va[i].pv);
      // live inputs change mid-frame; drawing must keep using the old shadows
      set_live(10'd300, 10'd64, 10'd50, ~32'h200, 10'd300, 10'd440, 1'b1);
      px(10'd10,  10'd200, 1, BLK, 1'b1);
      px(10'd100, 10'd447, 1, GRN, 1'b1);
      px(10'd300, 10'd447, 1, BLK, 1'b1);
      px(10'd300, 10'd440, 1, BLK, 1'b1);
      // reset held 3 cycles mid-line while the player sprite is in the pipeline
      repeat (3) px(10'd107, 10'd440, 0, BLK, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         px(10'(108 + i), 10'd440, 0, BLK, 1'b0);
         @(negedge clk);
         chk($sformatf("reset cycle %0d {rgb,valid,frame_start}", i),
             {6'd0, bus.VGA_R, bus.VGA_G, bus.VGA_B, bus.pixel_valid, bus.frame_start}, 32'd0);
      end
      rst = 1'b0;
      px(10'd107, 10'd440, 1, BLK, 1'b1);
      px(10'd64,  10'd50,  1, BLK, 1'b1);
      load(10'd300, 10'd64, 10'd50, ~32'h200, 10'd300, 10'd440, 1'b1);
      for (int i = 0; i < $size(vb); i++) px(vb[i].h, vb[i].v, 1, vb[i].rgb, vb[i].pv);
      load(10'd630, 10'd64, 10'd470, ~32'h200, 10'd1020, 10'd440, 1'b1);
      for (int i = 0; i < $size(vc); i++) px(vc[i].h, vc[i].v, 1, vc[i].rgb, vc[i].pv);
      repeat (4) px(10'd700, 10'd500, 0, BLK, 1'b0);
      chk("scoreboard drained", q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
